elevator_scheduler: RTL
=======================

Name: elevator_scheduler

Overview:
Car controller that sits between elevator_queue and the physical car model. It reads the queue's pending-floor vector and picks the next target with SCAN ordering: it keeps travelling in one direction while requests remain ahead. It times floor-to-floor travel and door dwell, and clears serviced floors in the queue. It also owns the queue's single write port and shares it between its own clear requests and floor writes from elevator_input_panel.

Parameters:
FLOOR_COUNT, 7, number of floors (floor indices 0..FLOOR_COUNT-1)
FLOOR_BITS, 3, width of floor index; must satisfy 2**FLOOR_BITS >= FLOOR_COUNT
TRAVEL_CYCLES, 16, clock cycles to move one floor (>=2)
DOOR_CYCLES, 32, clock cycles the door stays open (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset: asserted when low, released synchronously by the bench
queue_status  in  FLOOR_COUNT  pending-request vector from elevator_queue, bit n = floor n pending
panel_wr_valid  in  1  panel requests a floor write into the queue
panel_wr_floor  in  FLOOR_BITS  floor to write
panel_wr_ready  out  1  write port available to the panel this cycle
r_nwr  out  1  queue port: 1 = read/idle, 0 = write cycle
deassert_floor  out  1  queue port: with r_nwr=0, 1 = clear floor, 0 = set floor
requested_floor  out  FLOOR_BITS  queue port floor index
current_floor  out  FLOOR_BITS  floor the car is at or last passed
direction_up  out  1  1 = scanning up, 0 = scanning down
moving  out  1  car in motion
door_open  out  1  door open

Behaviour:
- Reset values (async on reset low):
  - state IDLE, current_floor 0, direction_up 1, moving 0, door_open 0.
  - r_nwr 1, deassert_floor 0, requested_floor 0, panel_wr_ready 0.
  - Counters 0.
- FSM states and transitions:
  - IDLE: evaluated on each edge.
    - queue_status[current_floor]=1 -> CLEAR.
    - Else any request above current_floor and (direction_up=1 or none below) -> direction_up<=1, MOVE.
    - Else any request below -> direction_up<=0, MOVE.
    - Else stay IDLE; direction_up holds.
  - MOVE: moving=1.
    - On entry the counter loads TRAVEL_CYCLES-1 and decrements each cycle.
    - At counter 0, current_floor steps ±1, so the floor changes TRAVEL_CYCLES cycles after MOVE is entered.
    - Then: bit set at the new floor -> CLEAR. Else request still ahead in direction -> reload counter, stay MOVE. Else -> IDLE, which re-evaluates and may reverse.
    - Never steps above FLOOR_COUNT-1 or below 0.
    - Requests behind the car are not serviced until the reversal.
  - CLEAR: exactly one cycle; moving=0.
    - Drives r_nwr=0, deassert_floor=1, requested_floor=current_floor.
    - Next state DOOR.
  - DOOR: door_open=1 for DOOR_CYCLES cycles, then IDLE.
    - A new request at current_floor arriving during DOOR is serviced again from IDLE (CLEAR, door reopens).
- Port arbitration (combinational mux, same cycle):
  - In CLEAR, the scheduler owns the port and panel_wr_ready=0.
  - Otherwise panel_wr_ready=1 (0 during reset).
  - On panel_wr_valid&panel_wr_ready: r_nwr=0, deassert_floor=0, requested_floor=panel_wr_floor.
  - Otherwise r_nwr=1, deassert_floor=0, and requested_floor holds its last value.
  - A stalled panel request must hold valid and floor stable until ready is high.
  - panel_wr_floor >= FLOOR_COUNT: accepted (ready=1) but dropped; r_nwr stays 1.
- Simultaneous events:
  - A queue bit set in the same cycle as arrival at that floor is serviced at that floor.
  - queue_status is sampled live; no internal copy.
- Reset mid-operation: all state returns to reset values immediately, and the car is reported at floor 0.

Optional Feature:
ELEVATOR_DOOR_HOLD_EN
- Defined: adds input door_hold (1 bit). While door_hold=1 in DOOR, the door counter reloads to DOOR_CYCLES-1, so the door stays open until door_hold has been low for DOOR_CYCLES cycles. door_hold has no effect in any other state.
- Undefined: the port is absent and the door dwell is fixed at DOOR_CYCLES.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=8):
1. Hold reset low, then check outputs -> r_nwr=1, deassert_floor=0, current_floor=0, direction_up=1, moving=0, door_open=0, panel_wr_ready=0.
2. From floor 0, queue_status=7'b0000100 -> MOVE next cycle; current_floor=1 after 4 cycles and 2 after 8; one-cycle CLEAR with r_nwr=0, deassert_floor=1, requested_floor=2; door_open=1 for 8 cycles; then IDLE.
3. Car at floor 3 moving up, queue_status bits 1 and 5 set (queue clears each on CLEAR) -> services 5 first, then direction_up=0 and services 1; order of CLEAR floors is 5, 1.
4. panel_wr_valid=1, panel_wr_floor=4 during the CLEAR cycle -> panel_wr_ready=0 and the clear is issued; next cycle r_nwr=0, deassert_floor=0, requested_floor=4.
5. IDLE at floor 0 with queue_status=7'b0000001 -> CLEAR on the next cycle, moving never asserted.
6. reset driven low mid-MOVE between floors 2 and 3 -> all outputs at reset values in the same cycle, with no CLEAR pulse.

Source files
------------

// File: rtl/elevator_scheduler_if.sv
// Queue-port and panel-write bundle shared by elevator_scheduler, elevator_queue and the input panel.
// master = scheduler side, slave = queue/panel side.
interface elevator_scheduler_if #(
    parameter int FLOOR_COUNT = 7,
    parameter int FLOOR_BITS  = 3
);
    logic [FLOOR_COUNT-1:0] queue_status;
    logic                   panel_wr_valid;
    logic [FLOOR_BITS-1:0]  panel_wr_floor;
    logic                   panel_wr_ready;
    logic                   r_nwr;
    logic                   deassert_floor;
    logic [FLOOR_BITS-1:0]  requested_floor;

    modport master (
        input  queue_status, panel_wr_valid, panel_wr_floor,
        output panel_wr_ready, r_nwr, deassert_floor, requested_floor
    );

    modport slave (
        output queue_status, panel_wr_valid, panel_wr_floor,
        input  panel_wr_ready, r_nwr, deassert_floor, requested_floor
    );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN-ordered elevator car controller that owns the queue write port and shares it with the panel.
// Optional macro ELEVATOR_DOOR_HOLD_EN adds a door_hold input that keeps the door open.
module elevator_scheduler #(
    parameter int FLOOR_COUNT   = 7,
    parameter int FLOOR_BITS    = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    elevator_scheduler_if.master  bus,
    output logic [FLOOR_BITS-1:0] current_floor,
    output logic                  direction_up,
    output logic                  moving,
    output logic                  door_open
);

    localparam int CNT_MAX  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_BITS = $clog2(CNT_MAX);
    localparam logic [CNT_BITS-1:0]   TRAVEL_LOAD = CNT_BITS'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]   DOOR_LOAD   = CNT_BITS'(DOOR_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]   CNT_ONE     = CNT_BITS'(1);
    localparam logic [FLOOR_BITS-1:0] TOP_FLOOR   = FLOOR_BITS'(FLOOR_COUNT - 1);
    localparam logic [FLOOR_BITS-1:0] FLOOR_ONE   = FLOOR_BITS'(1);

    typedef enum logic [1:0] {IDLE, MOVE, CLEAR, DOOR} state_t;

    state_t                state;
    logic [CNT_BITS-1:0]   cnt;
    logic [FLOOR_BITS-1:0] last_floor;

    logic                  req_here, req_above, req_below;
    logic [FLOOR_BITS-1:0] step_floor;
    logic                  step_here, step_ahead;
    logic                  port_ready, panel_in_range;

    function automatic logic any_above(input logic [FLOOR_COUNT-1:0] q,
                                       input logic [FLOOR_BITS-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (i > int'(f)) hit = hit | q[i];
        return hit;
    endfunction

    function automatic logic any_below(input logic [FLOOR_COUNT-1:0] q,
                                       input logic [FLOOR_BITS-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (i < int'(f)) hit = hit | q[i];
        return hit;
    endfunction

    // Look-ahead for the floor the car reaches when the travel counter expires.
    always_comb begin
        req_here   = bus.queue_status[current_floor];
        req_above  = any_above(bus.queue_status, current_floor);
        req_below  = any_below(bus.queue_status, current_floor);
        step_floor = current_floor;
        if (direction_up && current_floor != TOP_FLOOR)
            step_floor = current_floor + FLOOR_ONE;
        else if (!direction_up && current_floor != '0)
            step_floor = current_floor - FLOOR_ONE;
        step_here  = bus.queue_status[step_floor];
        step_ahead = direction_up ? any_above(bus.queue_status, step_floor)
                                  : any_below(bus.queue_status, step_floor);
    end

    // The scheduler's clear wins the port; otherwise the panel writes through in the same cycle.
    always_comb begin
        port_ready          = reset && (state != CLEAR);
        panel_in_range      = int'(bus.panel_wr_floor) < FLOOR_COUNT;
        bus.panel_wr_ready  = port_ready;
        bus.r_nwr           = 1'b1;
        bus.deassert_floor  = 1'b0;
        bus.requested_floor = last_floor;
        if (state == CLEAR) begin
            bus.r_nwr           = 1'b0;
            bus.deassert_floor  = 1'b1;
            bus.requested_floor = current_floor;
        end else if (bus.panel_wr_valid && port_ready && panel_in_range) begin
            bus.r_nwr           = 1'b0;
            bus.requested_floor = bus.panel_wr_floor;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_floor    <= '0;
            current_floor <= '0;
            direction_up  <= 1'b1;
            moving        <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            last_floor <= bus.requested_floor;
            case (state)
                IDLE: begin
                    if (req_here) begin
                        state <= CLEAR;
                    end else if (req_above && (direction_up || !req_below)) begin
                        direction_up <= 1'b1;
                        moving       <= 1'b1;
                        cnt          <= TRAVEL_LOAD;
                        state        <= MOVE;
                    end else if (req_below) begin
                        direction_up <= 1'b0;
                        moving       <= 1'b1;
                        cnt          <= TRAVEL_LOAD;
                        state        <= MOVE;
                    end
                end
                MOVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        current_floor <= step_floor;
                        if (step_here) begin
                            moving <= 1'b0;
                            state  <= CLEAR;
                        end else if (step_ahead) begin
                            cnt <= TRAVEL_LOAD;
                        end else begin
                            moving <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    door_open <= 1'b1;
                    cnt       <= DOOR_LOAD;
                    state     <= DOOR;
                end
                DOOR: begin
`ifdef ELEVATOR_DOOR_HOLD_EN
                    if (door_hold)
                        cnt <= DOOR_LOAD;
                    else
`endif
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        door_open <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
